// File: rtl/instr_sequencer.sv
// Command FIFO between the keyboard decoder and the calculator control FSM.
// Replays queued {opcode, operand} pairs as fixed-width new_instruction pulses.
module instr_sequencer #(
  parameter int DEPTH       = 4,
  parameter int DW          = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  input  logic [2:0]               key_op,
  input  logic [DW-1:0]            key_data,
  input  logic                     ready,
  input  logic                     clr_err,
  output logic                     new_instruction,
  output logic [2:0]               instruction,
  output logic [DW-1:0]            operand,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_ovf,
  output logic                     err_op,
  output logic                     err_tmo
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + DW;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE_CODE = 3'b101;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_SETTLE   = 2'd2;
  localparam logic [1:0] S_WAIT_RDY = 2'd3;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            settle_q, settle_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ni_q, ni_d;
  logic [2:0]      instr_q, instr_d;
  logic [DW-1:0]   oper_q, oper_d;
  logic            ovf_q, ovf_d, op_q, op_d, tmo_err_q, tmo_err_d;
  logic            legal, push_req, push_ok, pop, fifo_empty, fifo_full;
  logic            ovf_evt, tmo_evt;

  assign legal      = (key_op <= 3'd4);
  assign push_req   = key_valid & legal;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    ni_d     = ni_q;
    instr_d  = instr_q;
    oper_d   = oper_q;
    pop      = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      S_IDLE: pop = !fifo_empty && ready;
      S_ISSUE: begin
        if (hold_q == '0) begin
          ni_d     = 1'b0;
          instr_d  = IDLE_CODE;
          settle_d = 1'b0;
          state_d  = S_SETTLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_SETTLE: begin
        if (settle_q) begin
          tmo_d   = '0;
          state_d = S_WAIT_RDY;
        end else begin
          settle_d = 1'b1;
        end
      end
      S_WAIT_RDY: begin
        // ready here also serves as the idle pop decision, giving HOLD_CYCLES+3 spacing
        if (ready) begin
          state_d = S_IDLE;
          pop     = !fifo_empty;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_evt = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d           = S_ISSUE;
      ni_d              = 1'b1;
      {instr_d, oper_d} = mem_q[rd_ptr_q];
      hold_d            = HW'(HOLD_CYCLES - 1);
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end

    push_ok = push_req && (!fifo_full || pop);
    ovf_evt = push_req && fifo_full && !pop;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    op_d      = key_valid && !legal;
    ovf_d     = ovf_evt || (ovf_q && !clr_err);
    tmo_err_d = tmo_evt || (tmo_err_q && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {key_op, key_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      settle_q  <= 1'b0;
      tmo_q     <= '0;
      ni_q      <= 1'b0;
      instr_q   <= IDLE_CODE;
      oper_q    <= '0;
      ovf_q     <= 1'b0;
      op_q      <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      settle_q  <= settle_d;
      tmo_q     <= tmo_d;
      ni_q      <= ni_d;
      instr_q   <= instr_d;
      oper_q    <= oper_d;
      ovf_q     <= ovf_d;
      op_q      <= op_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign new_instruction = ni_q;
  assign instruction     = instr_q;
  assign operand         = oper_q;
  assign busy            = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count      = count_q;
  assign err_ovf         = ovf_q;
  assign err_op          = op_q;
  assign err_tmo         = tmo_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a command queue model predicts the
// order, contents, width and spacing of issued pulses plus the error flags.
module tb_instr_sequencer;
  localparam int DEPTH = 4, DW = 4, HOLD = 2, TMO = 64;

  logic clk = 0, rst_n = 0;
  logic key_valid = 0, clr_err = 0, ready_man = 0, ready_w;
  logic [2:0] key_op = 0;
  logic [DW-1:0] key_data = 0;
  logic new_instruction, busy, err_ovf, err_op, err_tmo;
  logic [2:0] instruction;
  logic [DW-1:0] operand;
  logic [$clog2(DEPTH):0] fifo_count;

  instr_sequencer #(.DEPTH(DEPTH), .DW(DW), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_op(key_op),
    .key_data(key_data), .ready(ready_w), .clr_err(clr_err),
    .new_instruction(new_instruction), .instruction(instruction), .operand(operand),
    .busy(busy), .fifo_count(fifo_count), .err_ovf(err_ovf), .err_op(err_op),
    .err_tmo(err_tmo));

  always #5 clk = ~clk;

  // Control FSM stand-in: leaves IDLE on new_instruction, returns one cycle after it drops.
  bit mimic = 0;
  logic ni_d1 = 0;
  always @(posedge clk) ni_d1 <= new_instruction;
  assign ready_w = mimic ? !(new_instruction || ni_d1) : ready_man;

  typedef struct { int rise; logic [2:0] ins; logic [DW-1:0] op; int width; } rec_t;
  rec_t obs_q[$];
  int cyc = 0, hi_cnt = 0, rise_c = 0;
  logic prev_ni = 0;
  logic [2:0] r_ins;
  logic [DW-1:0] r_op;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ni = 0;
    end else begin
      if (new_instruction && !prev_ni) begin
        rise_c = cyc; r_ins = instruction; r_op = operand; hi_cnt = 0;
      end
      if (new_instruction) hi_cnt++;
      if (!new_instruction && prev_ni)
        obs_q.push_back('{rise: rise_c, ins: r_ins, op: r_op, width: hi_cnt});
      prev_ni = new_instruction;
    end
  end

  logic [6:0] exp_q[$];
  int mcount = 0, checks = 0, failures = 0;
  bit exp_ovf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [DW-1:0] d, input bit pop_now);
    key_valid = 1; key_op = op; key_data = d;
    if (op <= 3'd4) begin
      if (mcount < DEPTH || pop_now) begin
        exp_q.push_back({op, d});
        if (!pop_now) mcount++;
      end else exp_ovf = 1;
    end
    step();
    key_valid = 0;
  endtask

  task automatic drain(input int n, input bit chk_gap);
    int prev = 0;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      rec_t r;
      logic [6:0] e;
      while (obs_q.size() == 0 && w < 300) begin step(); w++; end
      if (obs_q.size() == 0) begin check("drain_timeout", 0, 1); return; end
      r = obs_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
      $display("issue ins=%b op=%h width=%0d at cycle %0d", r.ins, r.op, r.width, r.rise);
      check("instr", 32'(r.ins), 32'(e[6:4]));
      check("operand", 32'(r.op), 32'(e[3:0]));
      check("width", r.width, HOLD);
      if (chk_gap && i > 0) check("gap", r.rise - prev, HOLD + 3);
      prev = r.rise;
    end
    mcount = 0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 300) begin step(); w++; end
    check("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ni", 32'(new_instruction), 0);
    check("rst_instr", 32'(instruction), 32'h5);
    check("rst_operand", 32'(operand), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_errs", {29'd0, err_ovf, err_op, err_tmo}, 0);
    rst_n = 1;
    mimic = 1;
    step();

    // single LOAD 7
    push(3'b100, 4'h7, 0);
    drain(1, 0);
    wait_idle();
    check("load_count", 32'(fifo_count), 0);

    // ADD, SUB, DISP back to back
    push(3'b001, 4'($urandom), 0);
    push(3'b010, 4'($urandom), 0);
    push(3'b011, 4'($urandom), 0);
    drain(3, 1);
    wait_idle();

    // overflow with ready low
    mimic = 0; ready_man = 0; exp_ovf = 0;
    for (int i = 0; i < 5; i++) push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    check("ovf_count", 32'(fifo_count), DEPTH);
    check("ovf_flag", 32'(err_ovf), 32'(exp_ovf));
    clr_err = 1; step(); clr_err = 0;
    check("ovf_clr", 32'(err_ovf), 0);
    mimic = 1;
    drain(4, 1);
    wait_idle();

    // illegal opcode
    op = 3'($urandom_range(5, 7));
    push(op, 4'($urandom), 0);
    check("errop_pulse", 32'(err_op), 1);
    check("errop_count", 32'(fifo_count), 0);
    step();
    check("errop_clear", 32'(err_op), 0);
    repeat (20) step();
    check("errop_noissue", obs_q.size(), 0);

    // full with simultaneous push and pop
    mimic = 0; ready_man = 0;
    for (int i = 0; i < 4; i++) push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    check("full_count", 32'(fifo_count), DEPTH);
    ready_man = 1;
    push(3'($urandom_range(0, 4)), 4'($urandom), 1);
    mimic = 1;
    check("pushpop_count", 32'(fifo_count), DEPTH);
    check("pushpop_ovf", 32'(err_ovf), 0);
    drain(5, 1);
    wait_idle();

    // timeout with ready stuck low
    mimic = 0; ready_man = 1;
    push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    step();
    ready_man = 0;
    n = 0;
    push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    n++;
    while (!err_tmo && n < 200) begin step(); n++; end
    check("tmo_latency", n, HOLD + 2 + TMO);
    mimic = 1;
    drain(2, 0);
    check("tmo_sticky", 32'(err_tmo), 1);
    clr_err = 1; step(); clr_err = 0;
    check("tmo_clr", 32'(err_tmo), 0);
    wait_idle();

    // async reset in the middle of an issue
    push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    push(3'($urandom_range(0, 4)), 4'($urandom), 0);
    n = 0;
    while (!new_instruction && n < 50) begin step(); n++; end
    check("pre_rst_ni", 32'(new_instruction), 1);
    #2 rst_n = 0;
    #1;
    check("arst_ni", 32'(new_instruction), 0);
    check("arst_count", 32'(fifo_count), 0);
    check("arst_instr", 32'(instruction), 32'h5);
    #1 rst_n = 1;
    obs_q.delete(); exp_q.delete(); mcount = 0;
    repeat (20) step();
    check("arst_noissue", obs_q.size(), 0);
    check("arst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
